// File: rtl/mult_pkg.sv
// Shared definitions for the shift-add multiplier: default width, counter
// width and accumulator slice positions used by the datapath and its control FSM.
package mult_pkg;

    localparam int N_DEFAULT = 8;

    // Counter must be able to hold the value N itself.
    function automatic int cnt_width(input int n);
        return $clog2(n + 1);
    endfunction

    function automatic int acc_msb(input int n);
        return 2 * n;
    endfunction

    function automatic int acc_hi_lsb(input int n);
        return n;
    endfunction

    function automatic int acc_lo_msb(input int n);
        return n - 1;
    endfunction

endpackage

// File: rtl/mult_adder.sv
// Zero-extended N-bit adder producing an N+1-bit sum with carry out.
module mult_adder #(
    parameter int N = 8
) (
    input  logic [N-1:0] a,
    input  logic [N-1:0] b,
    output logic [N:0]   sum
);

    assign sum = {1'b0, a} + {1'b0, b};

endmodule

// File: rtl/mult_datapath.sv
// Command-driven shift-add multiplier datapath: accumulator, multiplicand
// register and saturating shift counter, sequenced by an external control FSM.
module mult_datapath
    import mult_pkg::*;
#(
    parameter int N       = N_DEFAULT,
    parameter int K_LIMIT = N
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           Load,
    input  logic           Sh,
    input  logic           Ad,
    input  logic [N-1:0]   Mplier,
    input  logic [N-1:0]   Mcand,
    output logic           K,
    output logic           M,
    output logic [2*N-1:0] Product
);

    localparam int CW     = cnt_width(N);
    localparam int A_MSB  = acc_msb(N);
    localparam int HI_LSB = acc_hi_lsb(N);
    localparam int LO_MSB = acc_lo_msb(N);

    logic [A_MSB:0] acc_reg, acc_next, acc_sum;
    logic [N-1:0]   mc_reg, mc_next;
    logic [CW-1:0]  cnt_reg, cnt_next;
    logic [N:0]     add_sum;

    mult_adder #(.N(N)) u_adder (
        .a   (acc_reg[A_MSB-1:HI_LSB]),
        .b   (mc_reg),
        .sum (add_sum)
    );

    // Add result feeds the shifter so Ad+Sh completes in one cycle.
    always_comb begin
        acc_sum  = acc_reg;
        acc_next = acc_reg;
        mc_next  = mc_reg;
        cnt_next = cnt_reg;
        if (Load) begin
            acc_next = {{(N+1){1'b0}}, Mplier};
            mc_next  = Mcand;
            cnt_next = '0;
        end else begin
            if (Ad) begin
                acc_sum = {add_sum, acc_reg[LO_MSB:0]};
            end
            if (Sh) begin
                acc_next = acc_sum >> 1;
                if (cnt_reg != CW'(N)) begin
                    cnt_next = cnt_reg + 1'b1;
                end
            end else begin
                acc_next = acc_sum;
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            acc_reg <= '0;
            mc_reg  <= '0;
            cnt_reg <= '0;
        end else begin
            acc_reg <= acc_next;
            mc_reg  <= mc_next;
            cnt_reg <= cnt_next;
        end
    end

    assign K       = (cnt_reg == CW'(K_LIMIT));
    assign M       = acc_reg[0];
    assign Product = acc_reg[A_MSB-1:0];

endmodule

// File: tb/tb_mult_datapath.sv
// Directed bench for mult_datapath at N=4 with hand-computed accumulator values.
module tb_mult_datapath;

    localparam int N = 4;

    logic           clk = 1'b0;
    logic           rst;
    logic           Load, Sh, Ad;
    logic [N-1:0]   Mplier, Mcand;
    logic           K, M;
    logic [2*N-1:0] Product;

    int n_assert = 0;
    int n_fail   = 0;

    mult_datapath #(.N(N)) dut (
        .clk     (clk),
        .rst     (rst),
        .Load    (Load),
        .Sh      (Sh),
        .Ad      (Ad),
        .Mplier  (Mplier),
        .Mcand   (Mcand),
        .K       (K),
        .M       (M),
        .Product (Product)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Apply one command cycle (called 1 time unit after a rising edge).
    task automatic step(input string name, input logic ld, input logic ad, input logic sh);
        Load = ld; Ad = ad; Sh = sh;
        @(posedge clk);
        #1;
        Load = 1'b0; Ad = 1'b0; Sh = 1'b0;
        $display("step %-8s ld=%0b ad=%0b sh=%0b -> acc=%03h K=%0b M=%0b Product=%0d",
                 name, ld, ad, sh, dut.acc_reg, K, M, Product);
    endtask

    task automatic chk_state(input string tag, input logic [8:0] acc, input logic k);
        chk({tag, "_acc"}, 32'(dut.acc_reg), 32'(acc));
        chk({tag, "_prod"}, 32'(Product), 32'(acc[7:0]));
        chk({tag, "_m"}, 32'(M), 32'(acc[0]));
        chk({tag, "_k"}, 32'(K), 32'(k));
    endtask

    initial begin
        rst = 1'b0; Load = 1'b0; Sh = 1'b0; Ad = 1'b0;
        Mplier = '0; Mcand = '0;
        #3;
        chk_state("reset", 9'h000, 1'b0);
        #9 rst = 1'b1;                 // release at t=12, between edges
        @(posedge clk); #1;

        // Separate Ad / Sh sequence, 1011 x 1101
        Mplier = 4'b1011; Mcand = 4'b1101;
        step("load", 1, 0, 0); chk_state("s1_load", 9'h00B, 0);
        Mplier = 4'b0000; Mcand = 4'b0000;
        step("idle", 0, 0, 0); chk_state("s1_idle", 9'h00B, 0);
        step("ad1", 0, 1, 0);  chk_state("s1_ad1", 9'h0DB, 0);
        step("sh1", 0, 0, 1);  chk_state("s1_sh1", 9'h06D, 0);
        step("ad2", 0, 1, 0);  chk_state("s1_ad2", 9'h13D, 0);
        step("sh2", 0, 0, 1);  chk_state("s1_sh2", 9'h09E, 0);
        step("sh3", 0, 0, 1);  chk_state("s1_sh3", 9'h04F, 0);
        step("ad4", 0, 1, 0);  chk_state("s1_ad4", 9'h11F, 0);
        step("sh4", 0, 0, 1);  chk_state("s1_sh4", 9'h08F, 1);
        chk("s1_product", 32'(Product), 32'd143);

        // Combined Ad+Sh, same operands
        Mplier = 4'b1011; Mcand = 4'b1101;
        step("load", 1, 0, 0); chk_state("s2_load", 9'h00B, 0);
        step("adsh1", 0, 1, 1); chk_state("s2_c1", 9'h06D, 0);
        step("adsh2", 0, 1, 1); chk_state("s2_c2", 9'h09E, 0);
        step("sh3", 0, 0, 1);   chk_state("s2_c3", 9'h04F, 0);
        step("adsh4", 0, 1, 1); chk_state("s2_c4", 9'h08F, 1);
        chk("s2_product", 32'(Product), 32'd143);

        // 1111 x 1111 with carry retention in ACC[8]
        Mplier = 4'b1111; Mcand = 4'b1111;
        step("load", 1, 0, 0); chk_state("s3_load", 9'h00F, 0);
        step("ad1", 0, 1, 0);  chk_state("s3_ad1", 9'h0FF, 0);
        step("sh1", 0, 0, 1);  chk_state("s3_sh1", 9'h07F, 0);
        step("ad2", 0, 1, 0);  chk_state("s3_ad2", 9'h16F, 0);
        step("sh2", 0, 0, 1);  chk_state("s3_sh2", 9'h0B7, 0);
        step("ad3", 0, 1, 0);  chk_state("s3_ad3", 9'h1A7, 0);
        chk("s3_carry", 32'(dut.acc_reg[8]), 32'd1);
        step("sh3", 0, 0, 1);  chk_state("s3_sh3", 9'h0D3, 0);
        step("ad4", 0, 1, 0);  chk_state("s3_ad4", 9'h1C3, 0);
        step("sh4", 0, 0, 1);  chk_state("s3_sh4", 9'h0E1, 1);
        chk("s3_product", 32'(Product), 32'd225);

        // Load priority over Ad and Sh
        Mplier = 4'b0011; Mcand = 4'b0101;
        step("ldadsh", 1, 1, 1); chk_state("s4_prio", 9'h003, 0);

        // Counter saturation
        Mplier = 4'b1011; Mcand = 4'b1101;
        step("load", 1, 0, 0); chk_state("s5_load", 9'h00B, 0);
        step("sh1", 0, 0, 1);  chk_state("s5_sh1", 9'h005, 0);
        step("sh2", 0, 0, 1);  chk_state("s5_sh2", 9'h002, 0);
        step("sh3", 0, 0, 1);  chk_state("s5_sh3", 9'h001, 0);
        step("sh4", 0, 0, 1);  chk_state("s5_sh4", 9'h000, 1);
        step("sh5", 0, 0, 1);  chk_state("s5_sh5", 9'h000, 1);
        step("sh6", 0, 0, 1);  chk_state("s5_sh6", 9'h000, 1);
        chk("s5_cnt", 32'(dut.cnt_reg), 32'd4);

        // Asynchronous reset mid-sequence
        step("load", 1, 0, 0); chk_state("s6_load", 9'h00B, 0);
        step("ad1", 0, 1, 0);  chk_state("s6_ad1", 9'h0DB, 0);
        #2 rst = 1'b0;
        #1 chk_state("s6_rst", 9'h000, 0);
        chk("s6_rst_cnt", 32'(dut.cnt_reg), 32'd0);
        step("sh_inrst", 0, 1, 1); chk_state("s6_ign", 9'h000, 0);
        #2 rst = 1'b1;
        @(posedge clk); #1;
        chk_state("s6_rel", 9'h000, 0);
        Mplier = 4'b0010; Mcand = 4'b0011;
        step("load", 1, 0, 0);  chk_state("s6_l", 9'h002, 0);
        step("sh1", 0, 0, 1);   chk_state("s6_c1", 9'h001, 0);
        step("adsh2", 0, 1, 1); chk_state("s6_c2", 9'h018, 0);
        step("sh3", 0, 0, 1);   chk_state("s6_c3", 9'h00C, 0);
        step("sh4", 0, 0, 1);   chk_state("s6_c4", 9'h006, 1);
        chk("s6_product", 32'(Product), 32'd6);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule

// File: doc/mult_datapath.md
MULT_DATAPATH -- requirements
Module: mult_datapath

Interface
REQ-001 Parameter N, default 8: operand width in bits, legal range 2..16.
REQ-002 Parameter K_LIMIT, default N: shift count at which K asserts, legal range 1..N.
REQ-003 clk  input  1  single clock; all state updates on the rising edge.
REQ-004 rst  input  1  asynchronous, active-low reset.
REQ-005 Load  input  1  command: initialise the accumulator and counter from the operands.
REQ-006 Sh  input  1  command: shift the accumulator right by one and increment the counter.
REQ-007 Ad  input  1  command: add the multiplicand into the accumulator upper half.
REQ-008 Mplier  input  N  multiplier operand; sampled on Load only.
REQ-009 Mcand  input  N  multiplicand operand; sampled on Load only.
REQ-010 K  output  1  counter-complete flag for the control FSM.
REQ-011 M  output  1  current multiplier LSB for the control FSM.
REQ-012 Product  output  2N  accumulated product.

Function
REQ-013 The block shall hold ACC, a (2N+1)-bit accumulator; MC, an N-bit multiplicand register; and CNT, a shift counter of clog2(N+1) bits.
REQ-014 Load shall set ACC to {(N+1) zeros, Mplier}, MC to Mcand and CNT to 0 at the next edge.
REQ-015 Ad alone shall set ACC[2N:N] to the (N+1)-bit sum of ACC[2N-1:N] and MC, zero-extended, with ACC[N-1:0] unchanged.
REQ-016 Sh alone shall set ACC to ACC logically shifted right by one, with 0 into bit 2N, and shall increment CNT.
REQ-017 Ad and Sh together shall compute the REQ-015 sum first, then shift that result right by one, in a single cycle, and shall increment CNT.
REQ-018 Load shall take priority over Ad and Sh; with Load high, Ad and Sh shall be ignored that cycle.
REQ-019 No command active shall hold all registers unchanged.
REQ-020 CNT shall saturate at N; a further Sh shall still shift ACC but shall leave CNT at N.
REQ-021 K shall be combinational and equal to (CNT == K_LIMIT).
REQ-022 M shall be combinational and equal to ACC[0].
REQ-023 Product shall be combinational and equal to ACC[2N-1:0].
REQ-024 Product shall be valid as Mplier*Mcand after exactly N Sh commands following Load, each preceded by Ad whenever M=1.
REQ-025 The block shall perform no sequencing of its own: it is command-driven, and all ordering belongs to the upstream control FSM.
REQ-026 Mplier and Mcand changes shall have no effect except on a Load cycle.

Reset
REQ-027 rst low shall immediately clear ACC, MC and CNT to 0, independent of clk.
REQ-028 While rst is low: K=0, M=0, Product=0; commands shall be ignored.
REQ-029 Reset asserted mid-operation shall abort it, and the first operation after release shall require a fresh Load.
REQ-030 Release of rst shall take effect at the first rising clk edge with rst high.

Structure
REQ-031 The default width N, the counter-width function and the ACC bit-slice index constants shall live in a shared multiplier package used by this block and the control FSM.
REQ-032 The N+1-bit adder shall be a separate sub-module named mult_adder, with inputs a[N-1:0] and b[N-1:0] and output sum[N:0]; all registers shall stay in mult_datapath.
REQ-033 A top-level wrapper shall connect K and M to the control FSM and take Load, Sh and Ad from it; the wrapper is outside this block.

Verification
REQ-034 N=4, Load with Mplier=1011 and Mcand=1101, then Ad,Sh,Ad,Sh,Sh,Ad,Sh -> ACC after each step: 0_0000_1011, 0_1101_1011, 0_0110_1101, 1_0011_1101, 0_1001_1110, 0_0100_1111, 1_0001_1111, 0_1000_1111; final Product=143, K=1 only after the 4th Sh.
REQ-035 Same operands, using combined Ad+Sh cycles wherever M=1 -> Product=143 after 4 cycles, with ACC identical to REQ-034 after each shift.
REQ-036 N=4, Load with 1111 and 1111, full sequence -> Product=225; an Ad with upper half 1111 gives ACC[8]=1, checking carry retention.
REQ-037 Load, Ad and Sh all high with Mplier=0011 and Mcand=0101 -> ACC=0_0000_0011, CNT=0, K=0.
REQ-038 Six Sh after Load with N=4 -> CNT holds at 4, K stays 1, ACC keeps shifting to 0.
REQ-039 rst pulsed low mid-sequence, asynchronously between edges -> ACC, CNT, K, M and Product read 0 immediately; a subsequent Load with 0010 and 0011 followed by the full sequence gives Product=6.
